banked_reg_file: RTL and testbench

BANKED_REG_FILE -- requirements
Module: banked_reg_file

---
 rtl/banked_reg_file_if.sv | 31 +++
 rtl/banked_reg_file.sv | 109 ++++++++++
 tb/tb_banked_reg_file.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/banked_reg_file_if.sv
// banked_reg_file_if: request/response bundle for the banked register file.
//   master: drives write/PC/read-address/mode/exception/return requests.
//   slave : returns read data, Mode, PC, Busy, Exc_Ack and Mode_Err.
interface banked_reg_file_if #(parameter int SIZE = 32);
    logic            Write_Reg;
    logic [3:0]      W_Addr;
    logic [SIZE-1:0] W_Data;
    logic            Write_PC;
    logic [SIZE-1:0] PC_New;
    logic [3:0]      R_Addr_A, R_Addr_B, R_Addr_C;
    logic [SIZE-1:0] R_Data_A, R_Data_B, R_Data_C;
    logic            Mode_Wr;
    logic [4:0]      Mode_New;
    logic            Exc_Req;
    logic [4:0]      Exc_Mode;
    logic [2:0]      Exc_Vec;
    logic            Ret_Req;
    logic [4:0]      Mode;
    logic [SIZE-1:0] PC;
    logic            Busy, Exc_Ack, Mode_Err;
    modport master (
        output Write_Reg, W_Addr, W_Data, Write_PC, PC_New, R_Addr_A, R_Addr_B, R_Addr_C,
               Mode_Wr, Mode_New, Exc_Req, Exc_Mode, Exc_Vec, Ret_Req,
        input  R_Data_A, R_Data_B, R_Data_C, Mode, PC, Busy, Exc_Ack, Mode_Err
    );
    modport slave (
        input  Write_Reg, W_Addr, W_Data, Write_PC, PC_New, R_Addr_A, R_Addr_B, R_Addr_C,
               Mode_Wr, Mode_New, Exc_Req, Exc_Mode, Exc_Vec, Ret_Req,
        output R_Data_A, R_Data_B, R_Data_C, Mode, PC, Busy, Exc_Ack, Mode_Err
    );
endinterface

// File: rtl/banked_reg_file.sv
// banked_reg_file: mode-banked R0-R14 + PC register file with exception entry/return sequencer.
//   Clk   : rising-edge clock
//   Clr_n : asynchronous active-low reset
//   bus   : banked_reg_file_if slave (writes, 3 combinational reads, mode/exception/return control)
module banked_reg_file #(
    parameter int              SIZE     = 32,
    parameter logic [SIZE-1:0] PC_RESET = '0,
    parameter logic [SIZE-1:0] VEC_BASE = '0
) (
    input logic              Clk,
    input logic              Clr_n,
    banked_reg_file_if.slave bus
);
    localparam logic [4:0] USR = 5'b10000, FIQ = 5'b10001, IRQ = 5'b10010, SVC = 5'b10011,
                           MON = 5'b10110, ABT = 5'b10111, HYP = 5'b11010, UND = 5'b11011,
                           SYS = 5'b11111;
    typedef enum logic [1:0] {IDLE, SAVE, VECTOR, RET} state_t;
    state_t          state;
    logic [SIZE-1:0] regs [33];
    logic [4:0]      spsr [7];
    logic [SIZE-1:0] pc;
    logic [4:0]      mode, tgt;
    logic [2:0]      vec;
    logic            busy, exc_ack, mode_err;
    function automatic logic legal(input logic [4:0] m);
        return m inside {USR, FIQ, IRQ, SVC, MON, ABT, HYP, UND, SYS};
    endfunction
    // SPSR slot per privileged mode; usr/sys never reach here
    function automatic logic [2:0] slot(input logic [4:0] m);
        return m == FIQ ? 3'd0 : m == IRQ ? 3'd1 : m == SVC ? 3'd2 : m == MON ? 3'd3 :
               m == ABT ? 3'd4 : m == UND ? 3'd5 : 3'd6;
    endfunction
    // Physical layout: 0-14 usr, 15-21 fiq R8-R14, 22-31 irq..und R13/R14 pairs, 32 hyp R13
    function automatic logic [5:0] phys(input logic [4:0] m, input logic [3:0] a);
        if (m == FIQ && a >= 4'd8) return 6'd7 + {2'b00, a};
        if (m inside {IRQ, SVC, MON, ABT, UND} && a >= 4'd13)
            return 6'd20 + {2'b00, slot(m), 1'b0} + (a == 4'd14 ? 6'd1 : 6'd0);
        if (m == HYP && a == 4'd13) return 6'd32;
        return {2'b00, a};
    endfunction
    assign bus.R_Data_A = bus.R_Addr_A == 4'hF ? pc : regs[phys(mode, bus.R_Addr_A)];
    assign bus.R_Data_B = bus.R_Addr_B == 4'hF ? pc : regs[phys(mode, bus.R_Addr_B)];
    assign bus.R_Data_C = bus.R_Addr_C == 4'hF ? pc : regs[phys(mode, bus.R_Addr_C)];
    assign bus.Mode     = mode;
    assign bus.PC       = pc;
    assign bus.Busy     = busy;
    assign bus.Exc_Ack  = exc_ack;
    assign bus.Mode_Err = mode_err;
    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            for (int i = 0; i < 33; i++) regs[i] <= '0;
            for (int i = 0; i < 7; i++) spsr[i] <= USR;
            pc       <= PC_RESET;
            mode     <= SVC;
            tgt      <= USR;
            vec      <= '0;
            state    <= IDLE;
            busy     <= 1'b0;
            exc_ack  <= 1'b0;
            mode_err <= 1'b0;
        end else begin
            mode_err <= 1'b0;
            exc_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Write_Reg && bus.W_Addr != 4'hF) regs[phys(mode, bus.W_Addr)] <= bus.W_Data;
                    if (bus.Write_PC) pc <= bus.PC_New;
                    else if (bus.Write_Reg && bus.W_Addr == 4'hF) pc <= bus.W_Data;
                    if (bus.Exc_Req) begin
                        if (legal(bus.Exc_Mode) && !(bus.Exc_Mode inside {USR, SYS, HYP})) begin
                            tgt   <= bus.Exc_Mode;
                            vec   <= bus.Exc_Vec;
                            state <= SAVE;
                            busy  <= 1'b1;
                        end else mode_err <= 1'b1;
                    end else if (bus.Ret_Req) begin
                        if (mode inside {USR, SYS}) mode_err <= 1'b1;
                        else begin
                            state <= RET;
                            busy  <= 1'b1;
                        end
                    end else if (bus.Mode_Wr) begin
                        if (legal(bus.Mode_New)) mode <= bus.Mode_New;
                        else mode_err <= 1'b1;
                    end
                end
                SAVE: begin
                    regs[phys(tgt, 4'd14)] <= pc;
                    spsr[slot(tgt)]        <= mode;
                    exc_ack                <= 1'b1;
                    state                  <= VECTOR;
                end
                VECTOR: begin
                    mode  <= tgt;
                    pc    <= VEC_BASE + {{(SIZE-5){1'b0}}, vec, 2'b00};
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    pc <= regs[phys(mode, 4'd14)];
                    if (legal(spsr[slot(mode)])) mode <= spsr[slot(mode)];
                    else mode_err <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_banked_reg_file.sv
// tb_banked_reg_file: directed stimulus with a per-cycle behavioural model and literal spot checks.
module tb_banked_reg_file;
    localparam logic [4:0] USR = 5'b10000, FIQ = 5'b10001, IRQ = 5'b10010, SVC = 5'b10011,
                           MON = 5'b10110, ABT = 5'b10111, HYP = 5'b11010, UND = 5'b11011,
                           SYS = 5'b11111;
    logic Clk = 1'b0, Clr_n = 1'b0;
    int checks = 0, errors = 0;
    banked_reg_file_if #(.SIZE(32)) bus();
    banked_reg_file #(.SIZE(32), .PC_RESET(32'h0), .VEC_BASE(32'h0)) dut (.Clk(Clk), .Clr_n(Clr_n), .bus(bus));
    always #5 Clk = ~Clk;
    // model: each register copy is keyed by the mode code that owns it
    logic [31:0] m_reg [32][15];
    logic [4:0]  m_spsr [32];
    logic [31:0] m_pc;
    logic [4:0]  m_mode, m_tgt;
    logic [2:0]  m_vec;
    int          m_cnt;
    bit          m_exc, m_err;
    function automatic logic [4:0] owner(input logic [4:0] m, input logic [3:0] r);
        if (m == FIQ && r >= 8) return FIQ;
        if ((m == IRQ || m == SVC || m == MON || m == ABT || m == UND) && r >= 13) return m;
        if (m == HYP && r == 13) return HYP;
        return USR;
    endfunction
    function automatic bit is_legal(input logic [4:0] m);
        return m == USR || m == FIQ || m == IRQ || m == SVC || m == MON || m == ABT ||
               m == HYP || m == UND || m == SYS;
    endfunction
    function automatic logic [31:0] m_read(input logic [3:0] a);
        return a == 4'hF ? m_pc : m_reg[owner(m_mode, a)][a];
    endfunction
    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 15; j++) m_reg[i][j] = '0;
            m_spsr[i] = USR;
        end
        m_pc = '0; m_mode = SVC; m_tgt = USR; m_vec = '0; m_cnt = 0; m_exc = 0; m_err = 0;
    endtask
    task automatic model_edge();
        m_err = 0;
        if (m_cnt == 0) begin
            if (bus.Write_Reg && bus.W_Addr != 4'hF) m_reg[owner(m_mode, bus.W_Addr)][bus.W_Addr] = bus.W_Data;
            if (bus.Write_PC) m_pc = bus.PC_New;
            else if (bus.Write_Reg && bus.W_Addr == 4'hF) m_pc = bus.W_Data;
            if (bus.Exc_Req) begin
                if (is_legal(bus.Exc_Mode) && bus.Exc_Mode != USR && bus.Exc_Mode != SYS && bus.Exc_Mode != HYP) begin
                    m_tgt = bus.Exc_Mode; m_vec = bus.Exc_Vec; m_exc = 1; m_cnt = 2;
                end else m_err = 1;
            end else if (bus.Ret_Req) begin
                if (m_mode == USR || m_mode == SYS) m_err = 1;
                else begin m_exc = 0; m_cnt = 1; end
            end else if (bus.Mode_Wr) begin
                if (is_legal(bus.Mode_New)) m_mode = bus.Mode_New;
                else m_err = 1;
            end
        end else begin
            if (m_exc && m_cnt == 2) begin
                m_reg[owner(m_tgt, 4'd14)][14] = m_pc;
                m_spsr[m_tgt] = m_mode;
            end else if (m_exc) begin
                m_mode = m_tgt;
                m_pc = 32'(m_vec) * 4;
            end else begin
                m_pc = m_reg[owner(m_mode, 4'd14)][14];
                if (is_legal(m_spsr[m_mode])) m_mode = m_spsr[m_mode];
                else m_err = 1;
            end
            m_cnt--;
        end
    endtask
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask
    always @(negedge Clk) begin
        chk("mode", 32'(bus.Mode), 32'(m_mode));
        chk("pc", bus.PC, m_pc);
        chk("busy", 32'(bus.Busy), 32'(m_cnt > 0));
        chk("exc_ack", 32'(bus.Exc_Ack), 32'(m_exc && m_cnt == 1));
        chk("mode_err", 32'(bus.Mode_Err), 32'(m_err));
        chk("rdata_a", bus.R_Data_A, m_read(bus.R_Addr_A));
        chk("rdata_b", bus.R_Data_B, m_read(bus.R_Addr_B));
        chk("rdata_c", bus.R_Data_C, m_read(bus.R_Addr_C));
    end
    task automatic step();
        @(posedge Clk);
        if (Clr_n) model_edge();
        #1;
        bus.Write_Reg = 0; bus.Write_PC = 0; bus.Mode_Wr = 0; bus.Exc_Req = 0; bus.Ret_Req = 0;
    endtask
    task automatic set_mode(input logic [4:0] m);
        bus.Mode_Wr = 1; bus.Mode_New = m; step();
    endtask
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.Write_Reg = 1; bus.W_Addr = a; bus.W_Data = d; step();
    endtask
    task automatic exc(input logic [4:0] m, input logic [2:0] v);
        bus.Exc_Req = 1; bus.Exc_Mode = m; bus.Exc_Vec = v; step();
    endtask
    task automatic ret();
        bus.Ret_Req = 1; step();
    endtask
    initial begin
        bus.Write_Reg = 0; bus.W_Addr = 0; bus.W_Data = 0; bus.Write_PC = 0; bus.PC_New = 0;
        bus.Mode_Wr = 0; bus.Mode_New = 0; bus.Exc_Req = 0; bus.Exc_Mode = 0; bus.Exc_Vec = 0;
        bus.Ret_Req = 0; bus.R_Addr_A = 13; bus.R_Addr_B = 8; bus.R_Addr_C = 14;
        model_reset();
        repeat (2) @(posedge Clk);
        #1 Clr_n = 1;
        chk("rst_mode", 32'(bus.Mode), 32'h13);
        chk("rst_pc", bus.PC, 32'h0);
        chk("rst_busy", 32'(bus.Busy), 32'h0);
        // banking usr vs fiq
        set_mode(USR);
        chk("mode_usr", 32'(bus.Mode), 32'h10);
        wr(13, 32'h11);
        set_mode(FIQ);
        wr(13, 32'h22);
        wr(8, 32'h33);
        set_mode(USR);
        chk("usr_r13", bus.R_Data_A, 32'h11);
        chk("usr_r8", bus.R_Data_B, 32'h0);
        set_mode(FIQ);
        chk("fiq_r13", bus.R_Data_A, 32'h22);
        chk("fiq_r8", bus.R_Data_B, 32'h33);
        // exception entry irq, vector 6
        bus.Write_PC = 1; bus.PC_New = 32'h100; set_mode(USR);
        chk("pre_pc", bus.PC, 32'h100);
        exc(IRQ, 6);
        chk("exc_busy1", 32'(bus.Busy), 32'h1);
        chk("exc_ack1", 32'(bus.Exc_Ack), 32'h0);
        step();
        chk("exc_busy2", 32'(bus.Busy), 32'h1);
        chk("exc_ack2", 32'(bus.Exc_Ack), 32'h1);
        step();
        chk("exc_busy3", 32'(bus.Busy), 32'h0);
        chk("exc_mode", 32'(bus.Mode), 32'h12);
        chk("exc_pc", bus.PC, 32'h18);
        chk("irq_r14", bus.R_Data_C, 32'h100);
        // return
        ret();
        chk("ret_busy", 32'(bus.Busy), 32'h1);
        step();
        chk("ret_mode", 32'(bus.Mode), 32'h10);
        chk("ret_pc", bus.PC, 32'h100);
        // error pulses
        set_mode(5'b00000);
        chk("err_mode_wr", 32'(bus.Mode_Err), 32'h1);
        chk("err_mode_kept", 32'(bus.Mode), 32'h10);
        step();
        chk("err_pulse_end", 32'(bus.Mode_Err), 32'h0);
        set_mode(SYS);
        ret();
        chk("err_ret_sys", 32'(bus.Mode_Err), 32'h1);
        chk("err_ret_busy", 32'(bus.Busy), 32'h0);
        exc(HYP, 3);
        chk("err_exc_hyp", 32'(bus.Mode_Err), 32'h1);
        chk("err_hyp_mode", 32'(bus.Mode), 32'h1f);
        // write priority: Write_PC beats Write_Reg to R15
        bus.Write_PC = 1; bus.PC_New = 32'h80; wr(15, 32'h40);
        chk("prio_pc", bus.PC, 32'h80);
        // writes ignored while busy
        bus.R_Addr_A = 0;
        exc(SVC, 1);
        bus.Write_PC = 1; bus.PC_New = 32'h999; bus.Mode_Wr = 1; bus.Mode_New = USR;
        wr(0, 32'hdead);
        step();
        chk("busy_r0", bus.R_Data_A, 32'h0);
        chk("busy_pc", bus.PC, 32'h4);
        chk("busy_mode", 32'(bus.Mode), 32'h13);
        chk("svc_r14", bus.R_Data_C, 32'h80);
        ret();
        step();
        chk("svc_ret_mode", 32'(bus.Mode), 32'h1f);
        // hyp: private R13, shared R14
        bus.R_Addr_A = 13;
        set_mode(HYP);
        wr(13, 32'h55);
        wr(14, 32'h66);
        set_mode(USR);
        chk("hyp_usr_r13", bus.R_Data_A, 32'h11);
        chk("hyp_usr_r14", bus.R_Data_C, 32'h66);
        set_mode(HYP);
        chk("hyp_r13", bus.R_Data_A, 32'h55);
        ret();
        step();
        chk("hyp_ret_mode", 32'(bus.Mode), 32'h10);
        chk("hyp_ret_pc", bus.PC, 32'h66);
        // reset during SAVE
        set_mode(USR);
        exc(IRQ, 2);
        #2 Clr_n = 0;
        model_reset();
        #1;
        chk("mid_rst_mode", 32'(bus.Mode), 32'h13);
        chk("mid_rst_pc", bus.PC, 32'h0);
        chk("mid_rst_busy", 32'(bus.Busy), 32'h0);
        chk("mid_rst_ack", 32'(bus.Exc_Ack), 32'h0);
        @(posedge Clk);
        #1 Clr_n = 1;
        set_mode(IRQ);
        chk("mid_rst_irq_r14", bus.R_Data_C, 32'h0);
        chk("mid_rst_irq_mode", 32'(bus.Mode), 32'h12);
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
